// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer.
// One valid/ready input stream is steered by in_sel into one of N_OUTS
// output channels. Each channel owns a 2-entry FIFO, so the input never
// waits on a consumer combinationally: in_ready looks only at channel
// occupancy flops and in_sel.
// Optional feature macro: DEMUX_ROUTER_STATS_EN adds stat_cnt, a
// per-channel 16-bit wrapping count of accepted enqueues.

// Per-channel 2-entry FIFO with an EMPTY/ONE/FULL occupancy state.
module demux_router_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic             rdy,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] dout
`ifdef DEMUX_ROUTER_STATS_EN
  , output logic [15:0]    stat_cnt
`endif
);

  // Occupancy doubles as the entry count (0, 1, 2).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             state;
  occ_t             state_nxt;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WIDTH-1:0] mem [2];
  logic             deq;

  assign valid = (state != EMPTY);
  assign full  = (state == FULL);
  assign deq   = valid && rdy;
  assign dout  = mem[rd_ptr];

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Occupancy transitions from the enq/deq pair; enq+deq together holds.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (enq)         state_nxt = ONE;
      ONE: begin
        if (enq && !deq)      state_nxt = FULL;
        else if (!enq && deq) state_nxt = EMPTY;
      end
      FULL:  if (deq)         state_nxt = ONE;
      default:                state_nxt = EMPTY;
    endcase
  end

  // Pointers and storage; entries are cleared so out_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef DEMUX_ROUTER_STATS_EN
  // Accepted-enqueue counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)      stat_cnt <= '0;
    else if (enq) stat_cnt <= stat_cnt + 16'd1;
  end
`endif

endmodule

// Top: select decode, ready generation and illegal-select flagging.
module demux_router #(
  parameter  int WIDTH     = 32,
  parameter  int N_OUTS    = 2,
  localparam int SEL_WIDTH = $clog2(N_OUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [SEL_WIDTH-1:0]           in_sel,
  output logic [N_OUTS-1:0]              out_valid,
  input  logic [N_OUTS-1:0]              out_ready,
  output logic [N_OUTS-1:0][WIDTH-1:0]   out_data,
  output logic                           sel_err
`ifdef DEMUX_ROUTER_STATS_EN
  , output logic [N_OUTS-1:0][15:0]      stat_cnt
`endif
);

  localparam int                 N_SEL  = 1 << SEL_WIDTH;
  localparam logic [SEL_WIDTH:0] N_OUTS_W = N_OUTS[SEL_WIDTH:0];

  logic [N_OUTS-1:0] full;
  logic [N_SEL-1:0]  full_ext;
  logic              sel_legal;
  logic              accept;

  assign sel_legal = ({1'b0, in_sel} < N_OUTS_W);
  assign accept    = in_valid && in_ready;

  // Pad the full vector to the select range so an illegal in_sel indexes a 0.
  always_comb begin
    full_ext               = '0;
    full_ext[N_OUTS-1:0]   = full;
  end

  // Ready depends on registered occupancy and in_sel only; illegal selects
  // are always swallowed.
  always_comb begin
    in_ready = 1'b1;
    if (sel_legal) in_ready = !full_ext[in_sel];
  end

  // Flag a dropped illegal-select beat for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) sel_err <= 1'b0;
    else     sel_err <= accept && !sel_legal;
  end

  for (genvar i = 0; i < N_OUTS; i++) begin : g_chan
    logic enq;
    assign enq = accept && (in_sel == SEL_WIDTH'(i));

    demux_router_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .enq      (enq),
      .rdy      (out_ready[i]),
      .din      (in_data),
      .valid    (out_valid[i]),
      .full     (full[i]),
      .dout     (out_data[i])
`ifdef DEMUX_ROUTER_STATS_EN
      , .stat_cnt (stat_cnt[i])
`endif
    );
  end

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router with N_OUTS=3 (covers the illegal select).
module tb_demux_router;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [SW-1:0]     in_sel;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [N-1:0][W-1:0] out_data;
  logic              sel_err;
`ifdef DEMUX_ROUTER_STATS_EN
  logic [N-1:0][15:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_router #(.WIDTH(W), .N_OUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err)
`ifdef DEMUX_ROUTER_STATS_EN
    , .stat_cnt (stat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; out_ready = '0;
    drive(1'b1, 2'd0, 32'h5);

    // Reset with a live input beat: nothing gets in.
    chk("rst_ready", in_ready, 1);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_selerr", sel_err, 0);
    end
    chk("rst_data0", out_data[0], 0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0);
    step();
    chk("idle_valid", out_valid, 0);

    // Fill ch1 with consumer stalled.
    drive(1'b1, 2'd1, 32'hA1);
    chk("fill_rdy1", in_ready, 1);
    step();
    chk("fill_v1", out_valid, 3'b010);
    chk("fill_d1", out_data[1], 32'hA1);
    drive(1'b1, 2'd1, 32'hA2);
    step();
    chk("fill_v2", out_valid, 3'b010);
    chk("fill_d2", out_data[1], 32'hA1);
    drive(1'b1, 2'd1, 32'hA3);
    chk("full_rdy", in_ready, 0);
    out_ready = 3'b010; #1;
    chk("full_deq_rdy", in_ready, 0);
    out_ready = 3'b000;
    drive(1'b1, 2'd0, 32'h55);
    chk("other_rdy", in_ready, 1);
    drive(1'b0, 2'd0, 32'h0);
    out_ready = 3'b010;
    step();
    chk("drain_d", out_data[1], 32'hA2);
    chk("drain_v", out_valid, 3'b010);
    step();
    chk("drain_empty", out_valid, 0);

    // Back-to-back streaming into ch0.
    out_ready = 3'b111;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'd0, 32'h10 + k);
      chk("strm_rdy", in_ready, 1);
      step();
      chk("strm_v", out_valid, 3'b001);
      chk("strm_d", out_data[0], 32'h10 + k);
    end
    drive(1'b0, 2'd0, 32'h0);
    step();
    chk("strm_end", out_valid, 0);

    // Interleave ch0/ch1.
    out_ready = 3'b011;
    drive(1'b1, 2'd0, 32'd1); step();
    chk("il_v1", out_valid, 3'b001); chk("il_d1", out_data[0], 1);
    drive(1'b1, 2'd1, 32'd2); step();
    chk("il_v2", out_valid, 3'b010); chk("il_d2", out_data[1], 2);
    drive(1'b1, 2'd0, 32'd3); step();
    chk("il_v3", out_valid, 3'b001); chk("il_d3", out_data[0], 3);
    drive(1'b1, 2'd1, 32'd4); step();
    chk("il_v4", out_valid, 3'b010); chk("il_d4", out_data[1], 4);
    drive(1'b0, 2'd0, 32'h0); step();
    chk("il_end", out_valid, 0);

    // Illegal select with ch2 occupied.
    out_ready = 3'b000;
    drive(1'b1, 2'd2, 32'h77); step();
    chk("ill_pre_v", out_valid, 3'b100);
    chk("ill_pre_err", sel_err, 0);
    drive(1'b1, 2'd3, 32'hFF);
    chk("ill_rdy", in_ready, 1);
    step();
    chk("ill_err", sel_err, 1);
    chk("ill_v", out_valid, 3'b100);
    chk("ill_d", out_data[2], 32'h77);
    drive(1'b0, 2'd0, 32'h0); step();
    chk("ill_err_off", sel_err, 0);

    // Mid-operation reset with ch0 holding two entries.
    drive(1'b1, 2'd0, 32'hC1); step();
    drive(1'b1, 2'd0, 32'hC2); step();
    chk("mid_v", out_valid, 3'b101);
`ifdef DEMUX_ROUTER_STATS_EN
    chk("stat0", stat_cnt[0], 12);
    chk("stat1", stat_cnt[1], 4);
    chk("stat2", stat_cnt[2], 1);
`endif
    rst = 1'b1; out_ready = 3'b111;
    drive(1'b1, 2'd0, 32'hC3);
    step();
    chk("mid_rst_v", out_valid, 0);
    chk("mid_rst_d", out_data[0], 0);
    chk("mid_rst_err", sel_err, 0);
`ifdef DEMUX_ROUTER_STATS_EN
    chk("mid_rst_stat", stat_cnt, 0);
`endif
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0);
    step();
    chk("post_v", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-N demultiplexer; the inverse of the N-to-1 select mux.
- Accepts a single valid/ready input stream. Each beat carries a destination select, and the beat is steered into one of N output channels.
- Each output channel has a 2-entry buffer, so the input is decoupled from per-channel backpressure.
- Used between dispatch and per-functional-unit issue paths, where one instruction stream fans out to N consumers.

Parameters:
- WIDTH, 32, payload bits per beat.
- N_OUTS, 2, number of output channels; legal range 2..16.
- SEL_WIDTH, $clog2(N_OUTS), localparam; width of the destination select.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  router accepts the beat this cycle.
- in_data  input  WIDTH  input payload.
- in_sel  input  SEL_WIDTH  destination channel index.
- out_valid  output  N_OUTS  per-channel head valid.
- out_ready  input  N_OUTS  per-channel consumer accept.
- out_data  output  [N_OUTS-1:0][WIDTH-1:0]  per-channel head payload, packed array indexed by channel.
- sel_err  output  1  registered pulse: a beat with in_sel >= N_OUTS was accepted and dropped.

Behaviour:
- Channel storage:
  - Each channel i has a 2-entry FIFO with rd_ptr (1b), wr_ptr (1b) and cnt_i (2b, range 0..2).
- Handshakes:
  - Enqueue on channel i when in_valid && in_ready && in_sel==i.
  - Dequeue on channel i when out_valid[i] && out_ready[i].
- Ready:
  - in_ready = (cnt[in_sel] != 2) for a legal in_sel; 1 for an illegal in_sel.
  - in_ready depends only on registered state and in_sel. It never depends on out_ready, so there is no combinational ready path through the block.
- Output timing:
  - out_valid[i] = (cnt_i != 0).
  - out_data[i] = entry at rd_ptr_i, driven straight from flops.
  - Entries at non-head positions are don't-care.
- Latency: one cycle. A beat accepted at edge T is visible on out_valid/out_data after edge T. There is no same-cycle in-to-out bypass.
- Throughput: one beat per cycle total. A single channel sustains 1/cycle while its consumer holds out_ready high.
- Simultaneous enqueue and dequeue on the same channel:
  - cnt unchanged, both pointers advance.
  - This is legal only at cnt 1. At cnt 0 no dequeue exists; at cnt 2 in_ready=0.
  - At cnt 2, a concurrent dequeue does not raise in_ready in the same cycle.
- Independence: enqueue on channel j and dequeue on channel i (i != j) in the same cycle are independent.
- Ordering: strict FIFO per channel. There is no ordering guarantee across channels.
- Pointers: rd_ptr and wr_ptr wrap 1 -> 0.
- Illegal select:
  - Only possible when N_OUTS is not a power of two.
  - Behaviour: beat consumed (in_ready=1), data discarded, no channel state changes, sel_err=1 for exactly the following cycle.
- in_valid low: in_data and in_sel are ignored; no state change.
- Reset:
  - Synchronous. rst=1 at an edge clears all cnt, rd_ptr, wr_ptr and sel_err regardless of in/out handshakes that cycle.
  - Beats in flight are discarded.
  - During and after reset: out_valid=0, sel_err=0, out_data=0 (data entries are cleared).
  - in_ready is 1 during reset but no enqueue takes effect.
- No state machine beyond the per-channel counters. Each channel is a 3-state counter (EMPTY, ONE, FULL) with transitions set by the enq/deq pair.

Optional Feature:
- Macro: DEMUX_ROUTER_STATS_EN.
- Defined:
  - Adds output port stat_cnt  output  [N_OUTS-1:0][15:0], the per-channel count of accepted enqueues.
  - Each counter increments by 1 on an enqueue to its channel and wraps 0xFFFF -> 0x0000.
  - Counters are cleared by rst.
  - Illegal-select beats are not counted.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst 2 cycles with in_valid=1, in_sel=0. Required: out_valid=0, sel_err=0 throughout, and cnt stays 0 after rst falls with in_valid=0.
- Fill and backpressure: N_OUTS=2, out_ready=0, send 0xA1 then 0xA2 to ch1. Required: out_valid=2'b10, out_data[1]=0xA1, in_ready=0 on the third ch1 attempt, and in_ready=1 for in_sel=0 in the same cycle.
- Streaming: out_ready=1, send 0x10..0x17 back-to-back to ch0. Required: out_data[0] shows 0x10..0x17 on consecutive cycles, one cycle after each accept, in_ready held 1.
- Interleave: alternate in_sel 0/1 with payloads 1,2,3,4 and out_ready=2'b11. Required: ch0 outputs 1,3 and ch1 outputs 2,4, each in order.
- Illegal select: N_OUTS=3, send in_sel=3 with payload 0xFF. Required: in_ready=1, sel_err=1 the next cycle only, out_valid unchanged.
- Mid-operation reset: ch0 holds 2 entries and rst is asserted with in_valid=1 and out_ready=1 the same cycle. Required: out_valid=0 next cycle; with DEMUX_ROUTER_STATS_EN defined, stat_cnt reads 0.
